// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

   localparam int unsigned DEFAULT_XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   typedef enum logic {
      STEP_MUL,
      STEP_DIV
   } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on unsigned magnitudes.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = DEFAULT_XLEN
) (
   input  step_mode_t      mode,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] opnd,
   input  logic [XLEN-1:0] sreg,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] sreg_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum      = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : '0);
      shifted  = {acc, sreg[XLEN-1]};
      diff     = shifted - {1'b0, opnd};
      acc_nxt  = '0;
      sreg_nxt = '0;
      if (mode == STEP_DIV) begin
         // diff MSB set means the trial subtraction went negative: restore
         if (!diff[XLEN]) begin
            acc_nxt  = diff[XLEN-1:0];
            sreg_nxt = {sreg[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt  = shifted[XLEN-1:0];
            sreg_nxt = {sreg[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_nxt  = sum[XLEN:1];
         sreg_nxt = {sum[0], sreg[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: IDLE -> PREP -> CALC (XLEN cycles) -> FIX -> DONE.
// Define MULDIV_EARLY_OUT_EN to resolve div-by-zero, overflow and zero multiplies in PREP.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = DEFAULT_XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int unsigned CW = $clog2(XLEN);

   state_t            state;
   logic [2:0]        f3;
   logic [XLEN-1:0]   opnd;
   logic [XLEN-1:0]   acc;
   logic [XLEN-1:0]   sreg;
   logic [CW-1:0]     cnt;
   logic              neg;

   logic [XLEN-1:0]   acc_nxt;
   logic [XLEN-1:0]   sreg_nxt;
   logic              is_div;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fix_val;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode     (is_div ? STEP_DIV : STEP_MUL),
      .acc      (acc),
      .opnd     (opnd),
      .sreg     (sreg),
      .acc_nxt  (acc_nxt),
      .sreg_nxt (sreg_nxt)
   );

   // opnd/sreg hold the raw rs1/rs2 during PREP, magnitudes afterwards
   always_comb begin
      is_div   = f3[2];
      sign_a   = opnd[XLEN-1] & ((f3 == F3_MULH) | (f3 == F3_MULHSU) |
                                 (f3 == F3_DIV)  | (f3 == F3_REM));
      sign_b   = sreg[XLEN-1] & ((f3 == F3_MULH) | (f3 == F3_DIV) | (f3 == F3_REM));
      abs_a    = sign_a ? -opnd : opnd;
      abs_b    = sign_b ? -sreg : sreg;
      prod     = {acc, sreg};
      prod_fix = neg ? -prod : prod;
      fix_val  = '0;
      unique case (f3)
         F3_MUL:                       fix_val = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_val = neg ? -sreg : sreg;
         F3_REM, F3_REMU:              fix_val = neg ? -acc : acc;
         default:                      fix_val = '0;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early;
   logic [XLEN-1:0] early_val;

   always_comb begin
      early     = 1'b0;
      early_val = '0;
      if (is_div) begin
         if (sreg == '0) begin
            early     = 1'b1;
            early_val = f3[1] ? opnd : '1;
         end else if (!f3[0] && (opnd == {1'b1, {(XLEN-1){1'b0}}}) && (sreg == '1)) begin
            early     = 1'b1;
            early_val = f3[1] ? '0 : opnd;
         end
      end else if ((opnd == '0) || (sreg == '0)) begin
         early = 1'b1;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         f3       <= '0;
         opnd     <= '0;
         acc      <= '0;
         sreg     <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_result <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  f3     <= i_funct3;
                  opnd   <= i_op1;
                  sreg   <= i_op2;
                  o_busy <= 1'b1;
                  state  <= PREP;
               end
            end
            PREP: begin
`ifdef MULDIV_EARLY_OUT_EN
               if (early) begin
                  o_result <= early_val;
                  o_done   <= 1'b1;
                  state    <= DONE;
               end else
`endif
               begin
                  opnd  <= is_div ? abs_b : abs_a;
                  sreg  <= is_div ? abs_a : abs_b;
                  acc   <= '0;
                  cnt   <= CW'(XLEN - 1);
                  // a zero divisor keeps the all-ones quotient unsigned
                  neg   <= !is_div ? (sign_a ^ sign_b) :
                           f3[1]   ? sign_a :
                                     ((sign_a ^ sign_b) & (sreg != '0));
                  state <= CALC;
               end
            end
            CALC: begin
               acc  <= acc_nxt;
               sreg <= sreg_nxt;
               cnt  <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               o_result <= fix_val;
               o_done   <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; follows MULDIV_EARLY_OUT_EN for expected latency.
module tb_muldiv_seq;
   import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [2:0]  i_funct3;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;

   int n_chk;
   int n_pass;
   int done_pulses;

   muldiv_seq #(.XLEN(32)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_funct3 (i_funct3),
      .i_op1    (i_op1),
      .i_op2    (i_op2),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(negedge i_clk) begin
      if (o_done) done_pulses++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // caller sits 1 time unit after a rising edge with the DUT idle
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit early_vec);
      int lat;
      int busy_bad;
      int p0;
      p0       = done_pulses;
      i_funct3 = f3;
      i_op1    = a;
      i_op2    = b;
      i_start  = 1'b1;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      i_funct3 = ~f3;
      i_op1    = 32'hA5A5_5A5A;
      i_op2    = 32'h1234_5678;
      lat      = 1;
      busy_bad = 0;
      while (!o_done && lat < 60) begin
         if (!o_busy) busy_bad++;
         @(posedge i_clk); #1;
         lat++;
      end
      if (!o_busy) busy_bad++;
      check({tag, " done"}, o_done, 1);
      check({tag, " lat"}, lat, (early_vec && EARLY) ? 2 : 35);
      check({tag, " res"}, o_result, exp);
      check({tag, " busy"}, busy_bad, 0);
      @(posedge i_clk); #1;
      check({tag, " idle"}, {o_busy, o_done}, 0);
      check({tag, " held"}, o_result, exp);
      check({tag, " pulses"}, done_pulses - p0, 1);
   endtask

   initial begin
      int lat;
      int p0;
      n_chk       = 0;
      n_pass      = 0;
      done_pulses = 0;
      i_rst       = 1'b1;
      i_start     = 1'b0;
      i_funct3    = '0;
      i_op1       = '0;
      i_op2       = '0;
      #12;
      check("reset", {o_busy, o_done, o_result}, 0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      run_op("mul",      F3_MUL,    32'd7,        32'd6,        32'h0000_002A, 1'b0);
      run_op("mul_neg",  F3_MUL,    32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 1'b0);
      run_op("mulh",     F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mulhu",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("mul_zero", F3_MULH,   32'd0,        32'd5,        32'h0000_0000, 1'b1);
      run_op("div",      F3_DIV,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 1'b0);
      run_op("rem",      F3_REM,    32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 1'b0);
      run_op("div_nd",   F3_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      run_op("rem_nd",   F3_REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("divu",     F3_DIVU,   32'd100,      32'd7,        32'h0000_000E, 1'b0);
      run_op("remu",     F3_REMU,   32'd100,      32'd7,        32'h0000_0002, 1'b0);
      run_op("div0",     F3_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
      run_op("rem0",     F3_REM,    32'd5,        32'd0,        32'h0000_0005, 1'b1);
      run_op("div0_neg", F3_DIV,    32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFFF, 1'b1);
      run_op("rem0_neg", F3_REM,    32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9, 1'b1);
      run_op("divu0",    F3_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("rem_ovf",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

      // start pulses during CALC and in the DONE cycle must be ignored
      p0       = done_pulses;
      i_funct3 = F3_MUL;
      i_op1    = 32'd7;
      i_op2    = 32'd6;
      i_start  = 1'b1;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      lat      = 1;
      repeat (10) begin
         @(posedge i_clk); #1;
         lat++;
      end
      i_funct3 = F3_DIVU;
      i_op1    = 32'd100;
      i_op2    = 32'd7;
      i_start  = 1'b1;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      lat++;
      while (!o_done && lat < 60) begin
         @(posedge i_clk); #1;
         lat++;
      end
      check("ign lat", lat, 35);
      check("ign res", o_result, 32'h0000_002A);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      check("ign done_cyc", {o_busy, o_done}, 0);
      @(posedge i_clk); #1;
      check("ign not_acc", o_busy, 0);
      check("ign held", o_result, 32'h0000_002A);
      check("ign pulses", done_pulses - p0, 1);

      // asynchronous reset between edges in the middle of CALC
      i_funct3 = F3_DIV;
      i_op1    = 32'hFFFF_FFF9;
      i_op2    = 32'd2;
      i_start  = 1'b1;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      repeat (10) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      check("rst mid", {o_busy, o_done, o_result}, 0);
      #2;
      i_rst = 1'b0;
      p0    = done_pulses;
      repeat (40) @(posedge i_clk);
      #1;
      check("rst nodone", done_pulses - p0, 0);
      check("rst idle", o_busy, 0);
      run_op("post_rst", F3_DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the execute stage.
- Takes rs1/rs2 operands when the decoder flags an M-extension instruction.
- Runs a shift-add multiply or a restoring divide over XLEN cycles, and asserts o_busy so the pipeline control stalls fetch/decode/execute.
- Returns a RISC-V-compliant 32-bit result with a one-cycle done pulse for writeback muxing.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  request; accepted only in IDLE
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_op1  input  XLEN  rs1 data (multiplicand / dividend)
- i_op2  input  XLEN  rs2 data (multiplier / divisor)
- o_busy  output  1  high whenever state != IDLE
- o_done  output  1  one-cycle pulse, result valid
- o_result  output  XLEN  result; held until next accepted start

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_busy=0, o_done=0, o_result=0, all internal registers=0.
  - Reset mid-operation aborts immediately; no done pulse.
- States and transitions:
  - IDLE -> PREP on i_start. Capture funct3 and operands.
  - PREP (1 cycle): take absolute values for signed variants; record result sign; clear accumulator/remainder; counter = XLEN-1.
  - CALC (XLEN cycles): one iteration per cycle; counter decrements.
    - Multiply: 2*XLEN product register, shift-add.
    - Divide: restoring; remainder shifted left, subtract trial, quotient bit set.
  - CALC -> FIX when counter = 0.
  - FIX (1 cycle): apply sign (negate product/quotient/remainder per RISC-V rules); select high or low product half; load o_result.
  - FIX -> DONE. In DONE, o_done=1 for exactly one cycle; then DONE -> IDLE.
- Latency: i_start sampled in cycle N → PREP in N+1, CALC in N+2..N+33, FIX in N+34, o_done high in N+35. Back-to-back start is earliest in N+36 (IDLE).
- i_start while not IDLE (including the DONE cycle): ignored; no queueing.
- Operand/funct3 changes after acceptance: no effect.
- Arithmetic rules:
  - MUL: low 32 bits.
  - MULH: signed×signed high.
  - MULHSU: signed rs1 × unsigned rs2, high.
  - MULHU: unsigned high.
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000, REM = 0.
  - Remainder sign follows dividend.
- Result must be compliant regardless of latency path.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- Defined: in PREP, divide-by-zero, signed overflow, and multiply with either operand zero load the architectural result directly and go PREP -> DONE. o_done is then high in N+2.
- Undefined: every operation takes the fixed 35-cycle path. Results are identical; only latency differs.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state enum (IDLE, PREP, CALC, FIX, DONE);
  - XLEN default.
- One natural sub-module: muldiv_step, a combinational single-iteration unit.
  - Inputs: mode, accumulator/remainder, operand, shift register.
  - Outputs: next values.
  - Instantiated once inside the sequencer; the FSM and counters stay in muldiv_seq.

Test Plan:
- MUL 7 × 6 → o_result=0x0000002A, o_done in cycle N+35, o_busy high N+1..N+35.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIV 5 / 0 → 0xFFFFFFFF, REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. With MULDIV_EARLY_OUT_EN, o_done in N+2.
- i_start pulsed during CALC and in the DONE cycle → ignored; single o_done; o_result unchanged until the next accepted start.
- i_rst asserted mid-CALC (async, between edges) → o_busy=0, o_done=0, o_result=0 immediately; no done pulse; next start completes correctly.
